// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: drives one port of a synchronous SRAM with a 1-cycle registered read.
// Requests are accepted on a valid/ready handshake. Read data returns in order
// through a small response FIFO. An init engine fills the whole memory after
// reset and whenever init_start is pulsed.
module sram_port_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned           RSP_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]      RSP_LIMIT  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0]    FIFO_FULL  = CNT_W'(RSP_DEPTH);
  localparam logic [ADDR_WIDTH:0] SWEEP_LAST = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     sweep_cnt;
  logic                    init_pend;
  logic                    rd_pending;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic [DATA_WIDTH-1:0]   last_din;

  logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    credit_ok;
  logic                    accept;
  logic                    push;
  logic                    pop;

  // Handshake, credit check and SRAM port drive; all outputs are forced idle while rst_n is low.
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == FIFO_FULL);
    // Reads already issued but not yet popped (in flight or queued) consume FIFO credit.
    credit_ok  = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending}) < RSP_LIMIT;
    req_ready  = rst_n && (state == S_RUN) && !init_pend && credit_ok;
    accept     = req_valid && req_ready;
    rsp_valid  = rst_n && !fifo_empty;
    pop        = rsp_valid && rsp_ready;
    push       = rst_n && rd_pending;
    rsp_rdata  = fifo_empty ? '0 : fifo_mem[rd_ptr];
    init_busy  = !rst_n || (state == S_INIT) || init_pend;

    mem_we   = 1'b0;
    mem_addr = last_addr;
    mem_din  = last_din;
    if (rst_n) begin
      if (state == S_INIT) begin
        mem_we   = 1'b1;
        mem_addr = sweep_cnt[ADDR_WIDTH-1:0];
        mem_din  = INIT_VALUE;
      end else if (accept) begin
        mem_we   = req_we;
        mem_addr = req_addr;
        mem_din  = req_wdata;
      end
    end
  end

  // Control FSM: init sweep, pending-init drain, read-pending flag and held port values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_INIT;
      sweep_cnt  <= '0;
      init_pend  <= 1'b0;
      rd_pending <= 1'b0;
      last_addr  <= '0;
      last_din   <= '0;
    end else begin
      rd_pending <= accept && !req_we;
      if ((state == S_INIT) || accept) begin
        last_addr <= mem_addr;
        last_din  <= mem_din;
      end
      case (state)
        S_INIT: begin
          if (sweep_cnt == SWEEP_LAST) begin
            state     <= S_RUN;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (init_pend && !rd_pending && fifo_empty) begin
            state     <= S_INIT;
            init_pend <= 1'b0;
          end else if (init_start) begin
            init_pend <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      assert (!(push && fifo_full));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Response FIFO storage; captures SRAM read data the cycle after a read is issued.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed scenarios plus random traffic for sram_port_ctrl,
// checked against a behavioural model of memory contents and outstanding reads.
module tb_sram_port_ctrl;

  localparam int unsigned     DW    = 32;
  localparam int unsigned     AW    = 4;
  localparam int unsigned     DEPTH = 16;
  localparam int unsigned     RD    = 4;
  localparam logic [DW-1:0]   INITV = 32'hA5A5A5A5;

  logic          clk;
  logic          rst_n;
  logic          init_start;
  logic          init_busy;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  sram_port_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (DEPTH),
    .RSP_DEPTH (RD),
    .INIT_VALUE(INITV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_start(init_start),
    .init_busy (init_busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM port with a 1-cycle registered read.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  // Reference model: memory contents, outstanding reads with their accept cycle, init state.
  typedef struct packed {
    logic [DW-1:0] data;
    int unsigned   cyc;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            sweeping;
  bit            pend;
  int unsigned   sweep_idx;
  int unsigned   cyc_no;
  int unsigned   pops;
  int unsigned   checks;
  int unsigned   failures;
  bit            last_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    init_start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      #1;
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_init_busy", 32'(init_busy), 32'd1);
      @(negedge clk);
      cyc_no++;
    end
    rst_n = 1'b1;
    exp_q.delete();
    pend      = 1'b0;
    sweeping  = 1'b1;
    sweep_idx = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit rr, input bit ist, output bit acc);
    bit  exp_valid;
    bit  drained;
    rd_t e;
    req_valid  = v;
    req_we     = we;
    req_addr   = a;
    req_wdata  = d;
    rsp_ready  = rr;
    init_start = ist;
    #1;
    acc       = 1'b0;
    exp_valid = 1'b0;
    last_we   = mem_we;
    if (sweeping) begin
      chk("sweep_we", 32'(mem_we), 32'd1);
      chk("sweep_addr", 32'(mem_addr), sweep_idx);
      chk("sweep_din", mem_din, INITV);
      chk("sweep_req_ready", 32'(req_ready), 32'd0);
      chk("sweep_init_busy", 32'(init_busy), 32'd1);
      chk("sweep_rsp_valid", 32'(rsp_valid), 32'd0);
      sweep_idx++;
      if (sweep_idx == DEPTH) begin
        sweeping = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = INITV;
      end
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!pend && (exp_q.size() < int'(RD))));
      chk("init_busy", 32'(init_busy), 32'(pend));
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc_no);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) chk("rsp_rdata", rsp_rdata, exp_q[0].data);
      acc = v && req_ready;
      if (acc) begin
        chk("issue_we", 32'(mem_we), 32'(we));
        chk("issue_addr", 32'(mem_addr), 32'(a));
        chk("issue_din", mem_din, d);
      end else begin
        chk("idle_we", 32'(mem_we), 32'd0);
      end
      drained = pend && (exp_q.size() == 0);
      if (exp_valid && rr) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (acc) begin
        if (we) begin
          ref_mem[a] = d;
        end else begin
          e.data = ref_mem[a];
          e.cyc  = cyc_no;
          exp_q.push_back(e);
        end
      end
      if (drained) begin
        sweeping  = 1'b1;
        sweep_idx = 0;
        pend      = 1'b0;
      end else if (ist) begin
        pend = 1'b1;
      end
    end
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic drain(input int unsigned bound);
    bit acc;
    int unsigned n;
    n = 0;
    while ((exp_q.size() > 0 || sweeping || pend) && n < bound) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()) + 32'(sweeping) + 32'(pend), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  bit          acc;
  int unsigned k;
  int unsigned n_acc;
  int unsigned we_cnt;
  int unsigned pops0;

  initial begin
    checks = 0; failures = 0; cyc_no = 0; pops = 0;
    sweeping = 1'b0; pend = 1'b0; sweep_idx = 0;
    rst_n = 1'b0; init_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // Reset, then the power-up sweep; an init_start pulse during the sweep must be ignored.
    @(negedge clk);
    #1;
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < int'(DEPTH); i++)
      cycle(1'b0, 1'b0, '0, '0, 1'b1, (i == 5), acc);
    chk("ready_after_sweep", 32'(req_ready), 32'd1);
    chk("busy_after_sweep", 32'(init_busy), 32'd0);

    // Reads of swept memory.
    cycle(1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'd15, '0, 1'b1, 1'b0, acc);
    drain(10);

    // Write followed by a read of the same address in the next cycle.
    cycle(1'b1, 1'b1, 4'd5, 32'h1234, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, acc);
    chk("rd5_accept", 32'(acc), 32'd1);
    drain(10);

    // Credit limit under backpressure, then in-order release.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 4'(i), 32'(i * 3), 1'b1, 1'b0, acc);
    pops0 = pops;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 4'(k), '0, 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("reads_accepted_blocked", k, 32'd4);
    #1;
    chk("ready_low_when_full", 32'(req_ready), 32'd0);
    for (int i = 0; i < 30 && k < 8; i++) begin
      cycle(1'b1, 1'b0, 4'(k), '0, 1'b1, 1'b0, acc);
      if (acc) k++;
    end
    chk("reads_accepted_total", k, 32'd8);
    drain(20);
    chk("responses_popped", pops - pops0, 32'd8);

    // init_start with reads outstanding: sweep waits until every response is popped.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 4'(i), '0, 1'b0, 1'b0, acc);
      chk("pre_init_read_accept", 32'(acc), 32'd1);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0, acc);
      chk("pend_no_accept", 32'(acc), 32'd0);
    end
    drain(40);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'(i), '0, 1'b1, 1'b0, acc);
    drain(10);

    // Reset in the middle of a sweep restarts it from address 0.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 30 && !(sweeping && sweep_idx == 9); i++)
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("reached_sweep_addr9", sweep_idx, 32'd9);
    do_reset(1);
    we_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
      if (last_we) we_cnt++;
    end
    chk("restart_sweep_writes", we_cnt, 32'd16);

    // Random valid/ready traffic.
    n_acc = 0;
    for (int i = 0; i < 40000 && n_acc < 5000; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 1) != 0, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk("random_accepts", n_acc, 32'd5000);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Single-port requester/controller that drives one port of the team's synchronous dual-port SRAM (1-cycle registered read).
- Accepts read/write requests on a valid/ready interface and issues them to the SRAM port.
- Captures read data and returns it in order through a response FIFO with backpressure.
- Contains an init engine that sweeps the whole memory with a fill value after reset and on request.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 10, address width.
- MEM_DEPTH, 1<<ADDR_WIDTH, number of words swept by the init engine.
- RSP_DEPTH, 4, response FIFO depth; power of 2, >=2.
- INIT_VALUE, 0, word written by the init sweep.

Ports:
- clk  in  1  single clock; SRAM port clocked by the same clk.
- rst_n  in  1  synchronous, active-low reset.
- init_start  in  1  pulse; request a new init sweep.
- init_busy  out  1  high while a sweep is pending or running.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- mem_we  out  1  to SRAM we.
- mem_addr  out  ADDR_WIDTH  to SRAM addr.
- mem_din  out  DATA_WIDTH  to SRAM din.
- mem_dout  in  DATA_WIDTH  from SRAM dout; valid the cycle after a read is issued.

Behaviour:
- States: S_INIT, S_RUN.
- Reset (rst_n=0 at posedge): state=S_INIT, sweep counter=0, init_pend=0, rd_pending=0, FIFO empty, rsp_rdata=0.
- Output values while in reset: mem_we=0, req_ready=0, rsp_valid=0, init_busy=1.
- S_INIT:
  - Each cycle drives mem_we=1, mem_addr=counter, mem_din=INIT_VALUE; counter increments.
  - After writing MEM_DEPTH-1, the next state is S_RUN. A sweep takes exactly MEM_DEPTH cycles.
  - req_ready=0 throughout; init_start is ignored.
- S_RUN, issue path:
  - req_ready = !init_pend && (fifo_count + rd_pending < RSP_DEPTH). It is independent of req_valid and req_we.
  - On accept: mem_we=req_we, mem_addr=req_addr, mem_din=req_wdata, driven combinationally in the accept cycle.
  - When there is no accept: mem_we=0; mem_addr and mem_din hold the last issued values.
- Read path:
  - A read accepted at cycle T sets rd_pending for cycle T+1.
  - At T+1, mem_dout is pushed into the FIFO.
  - rsp_valid is high from T+2. Minimum read latency is 2 cycles.
  - Back-to-back reads sustain 1 per cycle while rsp_ready=1.
  - Responses are strictly in request order.
- Writes produce no response. A write followed by a read to the same address in the next cycle returns the new data.
- FIFO:
  - rsp_valid = !empty; rsp_rdata = head entry.
  - Pop on rsp_valid&&rsp_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - The credit rule guarantees no overflow. A push when full is an assertion failure.
- init_start in S_RUN sets init_pend=1, which immediately forces req_ready=0.
  - When rd_pending=0 and the FIFO is empty (all responses drained), the block enters S_INIT and clears init_pend.
  - init_start while init_pend=1 or in S_INIT has no additional effect.
- init_busy = (state==S_INIT) || init_pend.
- Reset mid-sweep or mid-traffic:
  - Pending reads and FIFO contents are discarded.
  - The sweep restarts from address 0 on the cycle after rst_n rises.
- Address counter width is ADDR_WIDTH+1 so MEM_DEPTH=2^ADDR_WIDTH terminates without wrap ambiguity.

Test Plan:
- ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5, release reset -> mem_we=1 for 16 cycles with addr 0..15; init_busy falls and req_ready rises on cycle 17; reads of addr 3 and 15 return A5A5A5A5.
- Write addr 5=0x1234 then read addr 5 the next cycle, rsp_ready=1 -> rsp_valid 2 cycles after the read accept, rsp_rdata=0x1234.
- Reads of addr 0..7 back to back (after writing data=addr*3), rsp_ready=0 -> exactly 4 reads accepted, then req_ready=0. Raise rsp_ready -> responses 0,3,6,9,12,15,18,21 in order and req_ready reasserts with no lost or duplicated response.
- Issue 3 reads, pulse init_start on the cycle after the last accept, hold rsp_ready=0 -> req_ready=0 and init_busy=1 immediately; no sweep begins until all 3 responses are popped; then a 16-cycle sweep runs and the previously written data reads back INIT_VALUE.
- Assert rst_n=0 at sweep address 9 for one cycle -> mem_we=0 during reset; the sweep restarts at address 0 and completes all 16 writes.
- Random valid/ready traffic (5000 requests) against a scoreboard model -> in-order data match, FIFO count never exceeds RSP_DEPTH, no push while full.
